// File: rtl/eva_ahb_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the EVA AHB slave memory.
package eva_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // Oversized transfers fall into the word lane set; half uses addr[1] only, so misalignment is ignored.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lo;
      HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        r[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/eva_ahb_slave_mem_if.sv
// AHB-lite bus bundle between the EVA master/decoder side and the slave memory.
interface eva_ahb_slave_mem_if;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/eva_ahb_slv_ram.sv
// Word-organised storage with a byte-enable write port and an asynchronous read port.
module eva_ahb_slv_ram #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  hclk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [0:(1 << DEPTH_LOG2) - 1];

  // Byte-lane write; the array itself is deliberately left without reset.
  always_ff @(posedge hclk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/eva_ahb_slave_mem.sv
// AHB-lite slave memory with programmable wait states and byte/half/word writes.
// Define EVA_AHB_SLV_ERR_EN to turn illegal accesses into two-cycle ERROR responses.
module eva_ahb_slave_mem
  import eva_ahb_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                 hclk,
  input logic                 hrest,
  eva_ahb_slave_mem_if.slave  bus
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic        hready_q, hready_d;
  logic [1:0]  hresp_q, hresp_d;
  logic [31:0] hrdata_q, hrdata_d;

  logic                  accept_s;
  logic                  illegal_s;
  logic                  we_s;
  logic [3:0]            be_s;
  logic [DEPTH_LOG2-1:0] widx_s, ridx_s;
  logic [31:0]           ram_rdata_s;
  logic [31:0]           fwd_rdata_s;

  assign accept_s = bus.hsel & bus.hready_in & bus.htrans[1];

`ifdef EVA_AHB_SLV_ERR_EN
  logic [31:0] offs_in_s;
  assign offs_in_s = bus.haddr - BASE_ADDR;

  // Out of window, oversized or misaligned transfers are rejected in the address phase.
  always_comb begin
    illegal_s = 1'b0;
    if ((offs_in_s >> (DEPTH_LOG2 + 2)) != 32'd0) begin
      illegal_s = 1'b1;
    end else if (bus.hsize > HSIZE_WORD) begin
      illegal_s = 1'b1;
    end else if ((bus.hsize == HSIZE_HALF) && bus.haddr[0]) begin
      illegal_s = 1'b1;
    end else if ((bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] != 2'b00)) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
  end
`else
  assign illegal_s = 1'b0;
`endif

  // Next-state and address-phase capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          addr_d  = bus.haddr;
          write_d = bus.hwrite;
          size_d  = bus.hsize;
          if (illegal_s) begin
            state_d = ST_ERR1;
          end else if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Index arithmetic truncates to the depth, giving wrap-around when errors are disabled.
  assign we_s   = (state_q == ST_DATA) & write_q;
  assign be_s   = byte_en(size_q, addr_q[1:0]);
  assign widx_s = DEPTH_LOG2'((addr_q - BASE_ADDR) >> 2);
  assign ridx_s = DEPTH_LOG2'((addr_d - BASE_ADDR) >> 2);

  eva_ahb_slv_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .hclk  (hclk),
    .we    (we_s),
    .be    (be_s),
    .waddr (widx_s),
    .wdata (bus.hwdata),
    .raddr (ridx_s),
    .rdata (ram_rdata_s)
  );

  // A read entering DATA on the edge that commits a write to the same word sees the new bytes.
  assign fwd_rdata_s = (we_s && (widx_s == ridx_s)) ? merge_bytes(ram_rdata_s, bus.hwdata, be_s)
                                                      : ram_rdata_s;

  // Registered response outputs derived from the state being entered.
  always_comb begin
    hready_d = 1'b1;
    hresp_d  = HRESP_OKAY;
    hrdata_d = 32'd0;
    if ((state_d == ST_WAIT) || (state_d == ST_ERR1)) begin
      hready_d = 1'b0;
    end else begin
      hready_d = 1'b1;
    end
    if ((state_d == ST_ERR1) || (state_d == ST_ERR2)) begin
      hresp_d = HRESP_ERROR;
    end else begin
      hresp_d = HRESP_OKAY;
    end
    if ((state_d == ST_DATA) && !write_d) begin
      hrdata_d = fwd_rdata_s;
    end else begin
      hrdata_d = 32'd0;
    end
  end

  // Control state and output registers.
  always_ff @(posedge hclk or posedge hrest) begin
    if (hrest) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      hrdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign bus.hready_out = hready_q;
  assign bus.hresp      = hresp_q;
  assign bus.hrdata     = hrdata_q;

endmodule

// File: tb/tb_eva_ahb_slave_mem.sv
// Self-checking bench: two slaves (0 and 3 wait states) on one shared AHB segment, byte-level memory model.
module tb_eva_ahb_slave_mem;

  localparam int          WC    [2] = '{0, 3};
  localparam logic [31:0] BASES [2] = '{32'h0000_0000, 32'h0000_1000};

  logic        hclk = 1'b0;
  logic        hrest = 1'b1;
  logic        sel0 = 1'b0, sel1 = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = 32'd0;
  logic        bus_hready;

  int tests = 0;
  int fails = 0;

  logic [7:0] mb [2][1024];
  bit          p_valid = 1'b0;
  int          p_d = 0;
  bit          p_wr = 1'b0;
  logic [31:0] p_a = 32'd0;
  logic [2:0]  p_s = 3'd0;
  logic [31:0] p_wd = 32'd0;
  logic [31:0] last_rd = 32'd0;

  eva_ahb_slave_mem_if if0 ();
  eva_ahb_slave_mem_if if1 ();

  assign bus_hready    = if0.hready_out & if1.hready_out;
  assign if0.hsel      = sel0;
  assign if1.hsel      = sel1;
  assign if0.htrans    = htrans;
  assign if1.htrans    = htrans;
  assign if0.hwrite    = hwrite;
  assign if1.hwrite    = hwrite;
  assign if0.haddr     = haddr;
  assign if1.haddr     = haddr;
  assign if0.hsize     = hsize;
  assign if1.hsize     = hsize;
  assign if0.hwdata    = hwdata;
  assign if1.hwdata    = hwdata;
  assign if0.hready_in = bus_hready;
  assign if1.hready_in = bus_hready;

  eva_ahb_slave_mem #(.DEPTH_LOG2(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .hclk (hclk), .hrest (hrest), .bus (if0)
  );
  eva_ahb_slave_mem #(.DEPTH_LOG2(8), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_1000)) u_dut1 (
    .hclk (hclk), .hrest (hrest), .bus (if1)
  );

  always #5 hclk = ~hclk;

  function automatic logic [31:0] dut_rdata(input int d);
    return (d == 1) ? if1.hrdata : if0.hrdata;
  endfunction
  function automatic logic [1:0] dut_hresp(input int d);
    return (d == 1) ? if1.hresp : if0.hresp;
  endfunction
  function automatic logic dut_hready(input int d);
    return (d == 1) ? if1.hready_out : if0.hready_out;
  endfunction

  function automatic bit legal(input int d, input logic [31:0] a, input logic [2:0] s);
`ifdef EVA_AHB_SLV_ERR_EN
    logic [31:0] off;
    off = a - BASES[d];
    if (off >= 32'd1024) return 1'b0;
    if (s > 3'd2) return 1'b0;
    if ((s == 3'd1) && a[0]) return 1'b0;
    if ((s == 3'd2) && (a[1:0] != 2'b00)) return 1'b0;
    return 1'b1;
`else
    return (d >= 0) && (a === a) && (s === s);
`endif
  endfunction

  function automatic logic [31:0] model_rd(input int d, input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASES[d]) & 32'h0000_03FC;
    return {mb[d][w + 3], mb[d][w + 2], mb[d][w + 1], mb[d][w]};
  endfunction

  task automatic model_wr(input int d, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    logic [31:0] off, start;
    int nb, idx;
    off   = (a - BASES[d]) & 32'h0000_03FF;
    nb    = (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
    start = off - (off % nb);
    for (int b = 0; b < nb; b++) begin
      idx = int'(start) + b;
      mb[d][idx] = wd[8 * (idx % 4) +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic complete(input int waits, input logic [1:0] wresp);
    bit leg;
    leg = legal(p_d, p_a, p_s);
    chk("wait_count", 32'(waits), leg ? 32'(WC[p_d]) : 32'd1);
    chk("hresp_final", {30'd0, dut_hresp(p_d)}, leg ? 32'd0 : 32'd1);
    if (!leg) chk("hresp_err1", {30'd0, wresp}, 32'd1);
    if (leg && !p_wr) begin
      chk("hrdata", dut_rdata(p_d), model_rd(p_d, p_a));
      last_rd = dut_rdata(p_d);
    end else begin
      chk("hrdata_zero", dut_rdata(p_d), 32'd0);
    end
    if (leg && p_wr) model_wr(p_d, p_a, p_s, p_wd);
  endtask

  // One bus beat: present an address phase (or idle), finish the pending data phase, then drive new data.
  task automatic op(input bit act, input int d, input bit wr, input logic [31:0] a,
                    input logic [2:0] s, input logic [31:0] wd, input logic [1:0] tr);
    int waits;
    bit done;
    logic [1:0] wresp;
    sel0   = act && (d == 0);
    sel1   = act && (d == 1);
    htrans = act ? tr : 2'b00;
    hwrite = wr;
    haddr  = a;
    hsize  = s;
    waits  = 0;
    done   = 1'b0;
    wresp  = 2'b00;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge hclk);
      if (bus_hready) begin
        done = 1'b1;
      end else begin
        waits++;
        if (p_valid) begin
          chk("hrdata_wait", dut_rdata(p_d), 32'd0);
          wresp = dut_hresp(p_d);
        end
      end
    end
    chk("hready_timeout", {31'd0, bus_hready}, 32'd1);
    if (p_valid) complete(waits, wresp);
    @(posedge hclk);
    #1;
    if (act && tr[1]) begin
      p_valid = 1'b1; p_d = d; p_wr = wr; p_a = a; p_s = s; p_wd = wd;
      hwdata = wr ? wd : $urandom;
    end else begin
      p_valid = 1'b0;
    end
  endtask

  task automatic flush();
    op(1'b0, 0, 1'b0, 32'd0, 3'd0, 32'd0, 2'b00);
  endtask

  initial begin
    int d;
    logic [31:0] a;
    logic [2:0] s;
    // Reset values on both slaves.
    repeat (3) @(negedge hclk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_hready", {31'd0, dut_hready(i)}, 32'd1);
      chk("rst_hresp", {30'd0, dut_hresp(i)}, 32'd0);
      chk("rst_hrdata", dut_rdata(i), 32'd0);
    end
    @(posedge hclk);
    #1 hrest = 1'b0;

    // Give the first 16 words of each slave known contents.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 16; w++) begin
        op(1'b1, i, 1'b1, BASES[i] + 32'(4 * w), 3'd2, $urandom, 2'b10);
      end
    end
    flush();

    // Zero-wait back-to-back write then read of the same word.
    op(1'b1, 0, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 2'b10);
    op(1'b1, 0, 1'b0, 32'h10, 3'd2, 32'd0, 2'b10);
    flush();
    chk("b2b_deadbeef", last_rd, 32'hDEAD_BEEF);

    // Three wait states on a read.
    op(1'b1, 1, 1'b0, BASES[1] + 32'h4, 3'd2, 32'd0, 2'b10);
    flush();

    // Byte then half writes merged into a word.
    op(1'b1, 0, 1'b1, 32'h10, 3'd2, 32'h1122_3344, 2'b10);
    op(1'b1, 0, 1'b1, 32'h13, 3'd0, 32'hA5A5_A5A5, 2'b10);
    op(1'b1, 0, 1'b0, 32'h10, 3'd2, 32'd0, 2'b10);
    flush();
    chk("byte_merge", last_rd, 32'hA522_3344);
    op(1'b1, 0, 1'b1, 32'h12, 3'd1, 32'h5A5A_5A5A, 2'b10);
    op(1'b1, 0, 1'b0, 32'h10, 3'd2, 32'd0, 2'b10);
    flush();
    chk("half_merge", last_rd, 32'h5A5A_3344);

    // Access just beyond the window: ERROR when enabled, wraps to word 0 otherwise.
    op(1'b1, 0, 1'b0, 32'h400, 3'd2, 32'd0, 2'b10);
    flush();

    // IDLE and BUSY while selected must leave the slave untouched.
    for (int i = 0; i < 4; i++) begin
      sel1 = 1'b1; htrans = i[0] ? 2'b01 : 2'b00; hwrite = 1'b1;
      haddr = BASES[1] + 32'h8; hsize = 3'd2; hwdata = $urandom;
      @(negedge hclk);
      chk("idle_hready", {31'd0, if1.hready_out}, 32'd1);
      chk("idle_hrdata", if1.hrdata, 32'd0);
      @(posedge hclk);
      #1;
    end
    sel1 = 1'b0; htrans = 2'b00;
    op(1'b1, 1, 1'b0, BASES[1] + 32'h8, 3'd2, 32'd0, 2'b10);
    flush();

    // Reset during the wait states of a write aborts it without committing.
    op(1'b1, 1, 1'b1, BASES[1] + 32'h20, 3'd2, 32'h1234_5678, 2'b10);
    sel1 = 1'b0; htrans = 2'b00;
    @(posedge hclk);
    #1 hrest = 1'b1;
    #1;
    chk("abort_hready", {31'd0, if1.hready_out}, 32'd1);
    chk("abort_hresp", {30'd0, if1.hresp}, 32'd0);
    chk("abort_hrdata", if1.hrdata, 32'd0);
    p_valid = 1'b0;
    repeat (2) @(posedge hclk);
    #1 hrest = 1'b0;
    op(1'b1, 1, 1'b0, BASES[1] + 32'h20, 3'd2, 32'd0, 2'b10);
    flush();

    // Randomized pipelined traffic against the byte model.
    for (int n = 0; n < 120; n++) begin
      d = int'($urandom_range(1, 0));
      a = BASES[d] + 32'($urandom_range(63, 0));
      if ($urandom_range(7, 0) == 0) a = a + 32'h400;
      s = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2, 0));
      if ($urandom_range(5, 0) == 0) begin
        flush();
      end else begin
        op(1'b1, d, 1'($urandom_range(1, 0)), a, s, $urandom, $urandom_range(1, 0) ? 2'b11 : 2'b10);
      end
    end
    flush();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule
